// File: rtl/demux16_stream_if.sv
// Producer/consumer bundle for demux16_stream: one input word with select, sixteen output holding registers.
// count exists only when DEMUX16_STREAM_STATS_EN is defined.
interface demux16_stream_if #(
  parameter int N = 1
);
  logic [N-1:0] in;
  logic [3:0]   select;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] out00, out01, out02, out03, out04, out05, out06, out07;
  logic [N-1:0] out08, out09, out10, out11, out12, out13, out14, out15;
  logic [15:0]  out_valid;
  logic [15:0]  out_ready;
`ifdef DEMUX16_STREAM_STATS_EN
  logic [15:0]  count;
`endif

  modport master (
    output in, select, in_valid, out_ready,
    input  in_ready, out_valid,
    input  out00, out01, out02, out03, out04, out05, out06, out07,
    input  out08, out09, out10, out11, out12, out13, out14, out15
`ifdef DEMUX16_STREAM_STATS_EN
    , input count
`endif
  );

  modport slave (
    input  in, select, in_valid, out_ready,
    output in_ready, out_valid,
    output out00, out01, out02, out03, out04, out05, out06, out07,
    output out08, out09, out10, out11, out12, out13, out14, out15
`ifdef DEMUX16_STREAM_STATS_EN
    , output count
`endif
  );
endinterface

// File: rtl/demux16_stream.sv
// Registered 1-to-16 valid/ready demux, one holding register per channel, 1-cycle latency; in_ready
// back-pressures only on the selected channel. DEMUX16_STREAM_STATS_EN adds a saturating accept counter.
module demux16_stream #(
  parameter int N = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  demux16_stream_if.slave bus
);

  logic [15:0]  vld_q, vld_d;
  logic [N-1:0] dat_q [16];
  logic [N-1:0] dat_d [16];
  logic         accept;

  // A full channel can still take a word in the same cycle its consumer drains it.
  assign bus.in_ready = rst_n & (~vld_q[bus.select] | bus.out_ready[bus.select]);
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    vld_d = vld_q & ~bus.out_ready;
    dat_d = dat_q;
    if (accept) begin
      vld_d[bus.select] = 1'b1;
      dat_d[bus.select] = bus.in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < 16; k++) dat_q[k] <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign bus.out_valid = vld_q;
  assign bus.out00 = dat_q[0];
  assign bus.out01 = dat_q[1];
  assign bus.out02 = dat_q[2];
  assign bus.out03 = dat_q[3];
  assign bus.out04 = dat_q[4];
  assign bus.out05 = dat_q[5];
  assign bus.out06 = dat_q[6];
  assign bus.out07 = dat_q[7];
  assign bus.out08 = dat_q[8];
  assign bus.out09 = dat_q[9];
  assign bus.out10 = dat_q[10];
  assign bus.out11 = dat_q[11];
  assign bus.out12 = dat_q[12];
  assign bus.out13 = dat_q[13];
  assign bus.out14 = dat_q[14];
  assign bus.out15 = dat_q[15];

`ifdef DEMUX16_STREAM_STATS_EN
  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (accept && count_q != 16'hFFFF) count_d = count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign bus.count = count_q;
`endif

endmodule

// File: tb/tb_demux16_stream.sv
// Bench for demux16_stream (N=8): vector table, hand corner sequences, random traffic vs. per-channel queue model.
module tb_demux16_stream;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  demux16_stream_if #(.N(8)) bus ();
  demux16_stream #(.N(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Model: each channel is a depth-1 queue; last[] is what the holding register shows.
  logic [7:0] mq [16][$];
  logic [7:0] last [16];
  int         mcnt;

  typedef struct {
    logic [7:0]  din;
    logic [3:0]  sel;
    logic        vld;
    logic [15:0] rdy;
    logic        e_ir;
    logic [15:0] e_vm;
    int          ch;
    logic [7:0]  e_dat;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] dout(input int k);
    case (k)
      0: return bus.out00;   1: return bus.out01;   2: return bus.out02;   3: return bus.out03;
      4: return bus.out04;   5: return bus.out05;   6: return bus.out06;   7: return bus.out07;
      8: return bus.out08;   9: return bus.out09;  10: return bus.out10;  11: return bus.out11;
      12: return bus.out12; 13: return bus.out13;  14: return bus.out14;  default: return bus.out15;
    endcase
  endfunction

  function automatic logic [15:0] model_vmask();
    logic [15:0] m = '0;
    for (int k = 0; k < 16; k++) m[k] = (mq[k].size() != 0);
    return m;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 16; k++) begin
      mq[k] = {};
      last[k] = 8'h00;
    end
    mcnt = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"}, {16'h0, bus.out_valid}, {16'h0, model_vmask()});
    for (int k = 0; k < 16; k++)
      chk($sformatf("%s.out%0d", tag, k), {24'h0, dout(k)}, {24'h0, last[k]});
`ifdef DEMUX16_STREAM_STATS_EN
    chk({tag, ".count"}, {16'h0, bus.count}, mcnt);
`endif
  endtask

  // Called at posedge+1: apply inputs, check in_ready, clock, update model, check outputs.
  task automatic drive_cycle(input logic [7:0] din, input logic [3:0] sel, input logic vld,
                             input logic [15:0] rdy, output logic ir);
    logic exp_ir;
    bus.in = din; bus.select = sel; bus.in_valid = vld; bus.out_ready = rdy;
    #1;
    exp_ir = (mq[sel].size() == 0) || rdy[sel];
    ir = bus.in_ready;
    chk("in_ready", {31'h0, bus.in_ready}, {31'h0, exp_ir});
    @(posedge clk);
    for (int k = 0; k < 16; k++)
      if (rdy[k] && mq[k].size() != 0) mq[k] = {};
    if (vld && exp_ir) begin
      mq[sel] = {};
      mq[sel].push_back(din);
      last[sel] = din;
      if (mcnt < 65535) mcnt++;
    end
    #1;
    check_outputs("cyc");
  endtask

  initial begin
    logic ir;
    model_reset();
    bus.in = '0; bus.select = '0; bus.in_valid = 1'b0; bus.out_ready = '0;
    #3;
    chk("rst.in_ready", {31'h0, bus.in_ready}, 32'h0);
    check_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    tbl[0] = '{8'hA5, 4'd7,  1'b1, 16'h0000, 1'b1, 16'h0080, 7,  8'hA5};
    tbl[1] = '{8'h3C, 4'd7,  1'b1, 16'h0000, 1'b0, 16'h0080, 7,  8'hA5};
    tbl[2] = '{8'h3C, 4'd2,  1'b1, 16'h0000, 1'b1, 16'h0084, 2,  8'h3C};
    tbl[3] = '{8'h11, 4'd15, 1'b1, 16'h0000, 1'b1, 16'h8084, 15, 8'h11};
    tbl[4] = '{8'h22, 4'd15, 1'b1, 16'h8000, 1'b1, 16'h8084, 15, 8'h22};
    tbl[5] = '{8'h00, 4'd7,  1'b0, 16'h0080, 1'b1, 16'h8004, 7,  8'hA5};
    tbl[6] = '{8'h55, 4'd2,  1'b0, 16'h0000, 1'b0, 16'h8004, 2,  8'h3C};
    for (int i = 0; i < 7; i++) begin
      drive_cycle(tbl[i].din, tbl[i].sel, tbl[i].vld, tbl[i].rdy, ir);
      chk($sformatf("tbl%0d.in_ready", i), {31'h0, ir}, {31'h0, tbl[i].e_ir});
      chk($sformatf("tbl%0d.out_valid", i), {16'h0, bus.out_valid}, {16'h0, tbl[i].e_vm});
      chk($sformatf("tbl%0d.data", i), {24'h0, dout(tbl[i].ch)}, {24'h0, tbl[i].e_dat});
    end

    // Stalled channel 7 blocks only words aimed at it.
    drive_cycle(8'hA5, 4'd7, 1'b1, 16'h0000, ir);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(8'h3C, 4'd7, 1'b1, 16'h0000, ir);
      chk("bp.in_ready", {31'h0, ir}, 32'h0);
      chk("bp.out07", {24'h0, bus.out07}, 32'hA5);
    end
    drive_cycle(8'h5A, 4'd2, 1'b1, 16'h0004, ir);
    chk("bp.sw.in_ready", {31'h0, ir}, 32'h1);
    chk("bp.sw.out02", {24'h0, bus.out02}, 32'h5A);

    // Back-to-back words into draining channel 15: no bubbles.
    for (int i = 0; i < 16; i++) begin
      drive_cycle(8'h40 + 8'(i), 4'd15, 1'b1, 16'h8000, ir);
      chk("stream.in_ready", {31'h0, ir}, 32'h1);
      chk("stream.out15", {24'h0, bus.out15}, {24'h0, 8'h40 + 8'(i)});
      chk("stream.vld15", {31'h0, bus.out_valid[15]}, 32'h1);
    end

    // Fill every channel, then drain all at once.
    for (int k = 0; k < 16; k++) drive_cycle(8'(k * 3 + 1), 4'(k), 1'b1, 16'h0000, ir);
    chk("fill.out_valid", {16'h0, bus.out_valid}, 32'hFFFF);
    drive_cycle(8'h00, 4'd0, 1'b0, 16'hFFFF, ir);
    chk("drain.out_valid", {16'h0, bus.out_valid}, 32'h0);
    chk("drain.out00", {24'h0, bus.out00}, 32'h01);
    chk("drain.out05", {24'h0, bus.out05}, 32'h10);

    // Asynchronous reset with channels 3 and 9 full and a word offered.
    drive_cycle(8'h33, 4'd3, 1'b1, 16'h0000, ir);
    drive_cycle(8'h99, 4'd9, 1'b1, 16'h0000, ir);
    bus.in = 8'h77; bus.select = 4'd4; bus.in_valid = 1'b1; bus.out_ready = '0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst.in_ready", {31'h0, bus.in_ready}, 32'h0);
    check_outputs("arst");
    @(posedge clk); #1;
    chk("arst.noacc", {16'h0, bus.out_valid}, 32'h0);
    chk("arst.out04", {24'h0, bus.out04}, 32'h0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_outputs("post_rst");

    // Random traffic, sparse ready so channels fill and stall.
    for (int i = 0; i < 400; i++)
      drive_cycle(8'($urandom), 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                  16'($urandom & $urandom & $urandom), ir);

`ifdef DEMUX16_STREAM_STATS_EN
    bus.in = 8'hC3; bus.select = 4'd0; bus.in_valid = 1'b1; bus.out_ready = 16'h0001;
    for (int i = 0; i < 70000; i++) @(posedge clk);
    #1;
    mcnt = 65535;
    for (int k = 0; k < 16; k++) if (k != 0 && mq[k].size() != 0) mq[k] = {};
    mq[0] = {}; mq[0].push_back(8'hC3); last[0] = 8'hC3;
    chk("stats.sat", {16'h0, bus.count}, 32'hFFFF);
    bus.in_valid = 1'b0; bus.out_ready = 16'hFFFF;
    @(posedge clk); #1;
    mq[0] = {};
    chk("stats.drain", {16'h0, bus.count}, 32'hFFFF);
    check_outputs("stats");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
